wash_phase_timer: RTL and testbench

Phase-duration timer that sits directly upstream of the washing-machine phase controller FSM. It feeds the controller's phase-finished input and consumes its current-phase code and counter-clear request. It converts the selected input clock frequency into a 1 s tick and counts seconds against a per-phase target. It signals completion when the active phase's time has elapsed, and exposes the remaining seconds for display.

---
 rtl/wash_pkg.sv | 38 +++
 rtl/wash_sec_prescaler.sv | 40 ++++
 rtl/wash_phase_timer.sv | 114 +++++++++++
 tb/tb_wash_phase_timer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine phase timer: controller phase
// codes, default phase durations and the clk_freq encoding.
package wash_pkg;

  // Phase codes as driven by the phase controller FSM
  typedef enum logic [2:0] {
    PH_IDLE  = 3'b000,
    PH_FILL  = 3'b001,
    PH_WASH  = 3'b011,
    PH_RINSE = 3'b111,
    PH_SPIN  = 3'b110
  } phase_e;

  // clk_freq encoding: ticks per second = BASE_CLK_HZ << code
  typedef enum logic [1:0] {
    FREQ_1X = 2'd0,
    FREQ_2X = 2'd1,
    FREQ_4X = 2'd2,
    FREQ_8X = 2'd3
  } freq_e;

  // Default phase durations (seconds) and clocking
  localparam int unsigned FILL_TIME_DEF  = 120;
  localparam int unsigned WASH_TIME_DEF  = 300;
  localparam int unsigned RINSE_TIME_DEF = 120;
  localparam int unsigned SPIN_TIME_DEF  = 60;
  localparam int unsigned BASE_CLK_DEF   = 1000000;
  localparam int unsigned SEC_W_DEF      = 10;

  // True for the four running phases; Idle and illegal codes are not active
  function automatic logic phase_active(input logic [2:0] code);
    case (code)
      PH_FILL, PH_WASH, PH_RINSE, PH_SPIN: phase_active = 1'b1;
      default:                             phase_active = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wash_sec_prescaler.sv
// Divides the system clock down to a one-cycle pulse per second. The divide
// ratio is BASE_CLK_HZ << freq and only advances while enable is high.
module wash_sec_prescaler
  import wash_pkg::*;
#(
  parameter int unsigned BASE_CLK_HZ = BASE_CLK_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] freq,
  input  logic       clear,
  input  logic       enable,
  output logic       sec_tick,
  output logic       pre_zero
);

  localparam int unsigned PW = $clog2(8 * BASE_CLK_HZ);
  localparam int unsigned TW = PW + 1;

  logic [PW-1:0] cnt;
  logic [TW-1:0] tps;
  logic          at_top;

  assign tps      = TW'(BASE_CLK_HZ) << freq;
  assign at_top   = ({1'b0, cnt} == (tps - 1'b1));
  assign sec_tick = enable && at_top;
  assign pre_zero = (cnt == '0);

  // Prescaler count: cleared on request, wraps at TPS-1 while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= at_top ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wash_phase_timer.sv
// Phase-duration timer feeding the washing-machine phase controller.
// Counts seconds against the active phase target and flags completion.
// Optional feature macro: WASH_TIMER_PAUSE_EN (honour timer_pause in Spin).
module wash_phase_timer
  import wash_pkg::*;
#(
  parameter int unsigned FILL_TIME_S  = FILL_TIME_DEF,
  parameter int unsigned WASH_TIME_S  = WASH_TIME_DEF,
  parameter int unsigned RINSE_TIME_S = RINSE_TIME_DEF,
  parameter int unsigned SPIN_TIME_S  = SPIN_TIME_DEF,
  parameter int unsigned BASE_CLK_HZ  = BASE_CLK_DEF,
  parameter int unsigned SEC_W        = SEC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       clk_freq,
  input  logic [2:0]       phase,
  input  logic             cnt_keep,
  input  logic             double_wash,
  input  logic             timer_pause,
  output logic             state_finish,
  output logic             sec_tick,
  output logic [SEC_W-1:0] remaining_s
);

  freq_e            freq_q;
  logic             dw_q;
  logic             armed_q;
  logic [SEC_W-1:0] sec_q;

  logic             active;
  logic             clear;
  logic             pre_zero;
  logic             wash_start;
  logic             dw_eff;
  logic             saturated;
  logic             paused;
  logic             enable;
  logic             tick;
  logic [SEC_W-1:0] target;

  assign active = phase_active(phase);
  assign clear  = !cnt_keep || !active;

`ifdef WASH_TIMER_PAUSE_EN
  assign paused = timer_pause && (phase == PH_SPIN);
`else
  logic pause_unused;
  assign pause_unused = timer_pause;
  assign paused       = 1'b0;
`endif

  // Target selection; the double-wash request is seen transparently in the
  // cycle it is latched so remaining_s is correct from the first Wash cycle.
  always_comb begin
    wash_start = (phase == PH_WASH) && (sec_q == '0) && pre_zero;
    dw_eff     = wash_start ? double_wash : dw_q;
    target     = '0;
    case (phase_e'(phase))
      PH_FILL:  target = SEC_W'(FILL_TIME_S);
      PH_WASH:  target = dw_eff ? SEC_W'(2 * WASH_TIME_S) : SEC_W'(WASH_TIME_S);
      PH_RINSE: target = SEC_W'(RINSE_TIME_S);
      PH_SPIN:  target = SEC_W'(SPIN_TIME_S);
      default:  target = '0;
    endcase
  end

  assign saturated = (sec_q >= target);
  // armed_q blocks counting after an asynchronous reset until the next clear
  assign enable    = armed_q && !clear && !saturated && !paused;

  wash_sec_prescaler #(
    .BASE_CLK_HZ(BASE_CLK_HZ)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .freq     (freq_q),
    .clear    (clear),
    .enable   (enable),
    .sec_tick (tick),
    .pre_zero (pre_zero)
  );

  // Frequency latch, arm flag and seconds counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_q  <= FREQ_1X;
      armed_q <= 1'b0;
      sec_q   <= '0;
    end else if (clear) begin
      freq_q  <= freq_e'(clk_freq);
      armed_q <= 1'b1;
      sec_q   <= '0;
    end else if (tick) begin
      sec_q   <= sec_q + 1'b1;
    end
  end

  // Double-wash latch: captured at the start of Wash, dropped in Idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dw_q <= 1'b0;
    end else if (!active) begin
      dw_q <= 1'b0;
    end else if (wash_start) begin
      dw_q <= double_wash;
    end
  end

  assign sec_tick     = tick;
  assign state_finish = armed_q && active && saturated;
  assign remaining_s  = (armed_q && active && !saturated) ? (target - sec_q) : '0;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Randomized bench for wash_phase_timer driven like the phase controller,
// compared cycle by cycle against a seconds-arithmetic reference model.
module tb_wash_phase_timer;

  localparam int BASE = 4;
  localparam int TF   = 3;
  localparam int TWS  = 5;
  localparam int TR   = 3;
  localparam int TS   = 2;
  localparam int RUNS = 14;
`ifdef WASH_TIMER_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] clk_freq;
  logic [2:0] phase;
  logic       cnt_keep;
  logic       double_wash;
  logic       timer_pause;
  logic       state_finish;
  logic       sec_tick;
  logic [9:0] remaining_s;

  wash_phase_timer #(
    .FILL_TIME_S (TF),
    .WASH_TIME_S (TWS),
    .RINSE_TIME_S(TR),
    .SPIN_TIME_S (TS),
    .BASE_CLK_HZ (BASE),
    .SEC_W       (10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_freq    (clk_freq),
    .phase       (phase),
    .cnt_keep    (cnt_keep),
    .double_wash (double_wash),
    .timer_pause (timer_pause),
    .state_finish(state_finish),
    .sec_tick    (sec_tick),
    .remaining_s (remaining_s)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: enabled-cycle count since the phase started
  int m_armed, m_fq, m_dw, m_ecyc;

  function automatic int tgt(input logic [2:0] ph, input int dw);
    case (ph)
      3'b001:  return TF;
      3'b011:  return (dw != 0) ? 2 * TWS : TWS;
      3'b111:  return TR;
      3'b110:  return TS;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_active(input logic [2:0] ph);
    return (ph == 3'b001) || (ph == 3'b011) || (ph == 3'b111) || (ph == 3'b110);
  endfunction

  logic [2:0] codes [5];
  int pidx, idle_left, sat_left, runs, resets;
  int tps, dweff, t, secs, act, fin, keep, clr, psd, en, e_tick, e_rem;
  bit do_rst;

  initial begin
    codes = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b110};
    rst_n = 1'b0; phase = 3'b000; cnt_keep = 1'b0; clk_freq = 2'd0;
    double_wash = 1'b0; timer_pause = 1'b0;
    m_armed = 0; m_fq = 0; m_dw = 0; m_ecyc = 0;
    pidx = 0; idle_left = 2; sat_left = 0; runs = 0; resets = 0;

    #12;
    check("reset_finish", state_finish, 0);
    check("reset_tick", sec_tick, 0);
    check("reset_remaining", remaining_s, 0);
    #6 rst_n = 1'b1;

    for (int cyc = 0; cyc < 40000 && runs < RUNS; cyc++) begin
      @(negedge clk);
      phase    = codes[pidx];
      clk_freq = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) double_wash = ~double_wash;
      timer_pause = ($urandom_range(0, 2) != 0);

      act   = is_active(phase);
      tps   = BASE << m_fq;
      dweff = (phase == 3'b011 && m_ecyc == 0) ? int'(double_wash) : m_dw;
      t     = tgt(phase, dweff);
      secs  = m_ecyc / tps;
      fin   = (m_armed != 0 && act != 0 && secs >= t) ? 1 : 0;

      if (pidx == 0) keep = $urandom_range(0, 1);
      else if (fin != 0) begin
        if (sat_left > 0) begin keep = 1; sat_left--; end
        else keep = 0;
      end else keep = ($urandom_range(0, 199) != 0) ? 1 : 0;
      cnt_keep = keep[0];

      clr    = (keep == 0 || act == 0) ? 1 : 0;
      psd    = (PAUSE_EN && timer_pause && phase == 3'b110) ? 1 : 0;
      en     = (m_armed != 0 && clr == 0 && secs < t && psd == 0) ? 1 : 0;
      e_tick = (en != 0 && (m_ecyc % tps) == tps - 1) ? 1 : 0;
      e_rem  = (m_armed != 0 && act != 0 && secs < t) ? t - secs : 0;

      #1;
      check("finish", state_finish, fin);
      check("tick", sec_tick, e_tick);
      check("remaining", remaining_s, e_rem);

      do_rst = (pidx != 0) && (($urandom_range(0, 999) == 0) ||
               (resets == 0 && runs >= 5 && pidx == 2 && m_ecyc > 20));
      if (do_rst) begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_finish", state_finish, 0);
        check("rst_tick", sec_tick, 0);
        check("rst_remaining", remaining_s, 0);
        m_armed = 0; m_fq = 0; m_dw = 0; m_ecyc = 0; en = 0;
        #1 rst_n = 1'b1;
        resets++;
      end

      // Model state advance at the coming clock edge
      if (act == 0) m_dw = 0;
      else if (phase == 3'b011 && m_ecyc == 0) m_dw = int'(double_wash);
      if (clr != 0) begin
        m_ecyc = 0; m_fq = int'(clk_freq); m_armed = 1;
      end else if (en != 0) m_ecyc++;

      // Controller behaviour
      if (do_rst) begin
        pidx = 0; idle_left = 2;
      end else if (pidx == 0) begin
        idle_left--;
        if (idle_left <= 0) begin
          pidx = 1;
          sat_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
        end
      end else if (fin != 0 && keep == 0) begin
        if (pidx == 4) begin
          pidx = 0; runs++; idle_left = $urandom_range(1, 3);
        end else begin
          pidx++;
          sat_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
        end
      end
    end

    check("runs_done", runs, RUNS);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
